quad_encoder_bank: RTL
======================

Name: quad_encoder_bank

Overview:
Parametrised successor to the 4-channel 8-bit quadrature encoder peripheral, for the TinyQV user-peripheral slot. It provides NUM_CH channels, each with debounced A/B inputs and a CNT_WIDTH-bit wrapping up/down counter. Each channel has a selectable x1/x2/x4/disabled decode mode, a direction bit and a sticky illegal-transition flag. Software reads atomic shadow snapshots of all counters through the 8-bit register port and can capture-and-clear them per channel.

Parameters:
NUM_CH, 4, number of encoder channels (1..4); channel n uses ui_in[2n]=A, ui_in[2n+1]=B.
CNT_WIDTH, 16, counter width (8..16); bits above CNT_WIDTH read 0.
HIST_LEN, 8, debounce history length in strobe samples (2..16).
STROBE_WIDTH, 16, width of the debounce strobe prescaler counter.

Ports:
clk  input  1  peripheral clock (64 MHz nominal)
reset  input  1  asynchronous active-high reset
ui_in  input  8  encoder pins, already synchronised upstream
uo_out  output  8  tied 8'h00
address  input  4  register address
data_write  input  1  write strobe, qualifies data_in
data_in  input  8  write data
data_out  output  8  combinational read data for address

Behaviour:
- Reset (async, all flops): debounce_cmp=128, mode=8'hAA (all x4), counters=0, shadows=0, direction=0, errors=0, prescaler=0, debounce histories=0, debounced outputs=0, previous A/B state=00. data_out follows address after reset; uo_out always 0.
- Register map (unlisted addresses read 0, writes ignored):
  - 0x0..0x7: shadow count of ch n; low byte at 2n, high byte at 2n+1. Read-only. Channels >= NUM_CH read 0.
  - 0x8: debounce_cmp, R/W.
  - 0x9: mode, R/W, 2 bits per channel: 00 x1, 01 x2, 10 x4, 11 disabled.
  - 0xA: status. [3:0] direction (1 = last count up); [7:4] sticky error flags. Writing 1 to bits [7:4] clears them; [3:0] read-only.
  - 0xB: capture. Any write copies all live counters to shadows in the same edge. data_in[n]=1 also clears the ch n live counter. Reads 0.
- Strobe: prescaler increments each clk. When prescaler==debounce_cmp (zero-extended), strobe=1 for one cycle and prescaler<=0. Period is cmp+1 cycles; cmp=0 gives strobe every cycle. Writing cmp below the current prescaler value lets the prescaler wrap at 2^STROBE_WIDTH before the next strobe (accepted).
- Debounce, per pin: shift the pin into the history on each strobe. Output goes 1 when the history is all ones, 0 when all zeros, and holds otherwise.
- Decode, per channel: prev<=(A_db,B_db) every clk.
  - Forward sequence AB: 00->10->11->01->00 counts up; the reverse sequence counts down.
  - x4: every valid transition counts.
  - x2: only transitions where A changes count.
  - x1: only 00->10 (up) and 10->00 (down) count.
  - Both bits changing in one cycle is illegal: no count, error[n]<=1. Errors are not flagged in disabled mode.
  - Disabled mode: counter and direction hold; prev still tracks.
  - A count updates the counter and direction[n] on the clk edge after the debounced change.
- Arithmetic: counter is modulo 2^CNT_WIDTH. Max value +1 -> 0; 0 -1 -> all ones.
- Simultaneous events:
  - Capture-and-clear in the same cycle as a count: shadow gets the pre-count value; the live counter loads that cycle's delta (0, +1 or all-ones). No count is lost.
  - Error set and error clear in the same cycle: set wins.
  - Mode write in the same cycle as a count: the old mode applies.
- Latency: pin change -> debounced after HIST_LEN consecutive agreeing strobes -> counter +1 clk -> visible after the next capture write.
- Reset mid-operation clears everything immediately. Pins held high need HIST_LEN strobes after release; the resulting 00->11 jump flags an error (documented behaviour).

Decomposition:
- Shared package quad_encoder_pkg holds:
  - mode encodings (MODE_X1, MODE_X2, MODE_X4, MODE_OFF);
  - address constants (ADDR_CNT_BASE, ADDR_DEB_CMP=0x8, ADDR_MODE=0x9, ADDR_STATUS=0xA, ADDR_CAPTURE=0xB);
  - reset constants DEB_CMP_RST=128 and MODE_RST=8'hAA.
- One sub-module, quad_channel (params CNT_WIDTH, HIST_LEN): two debouncers, prev-state decoder, counter, direction and error logic.
  - Inputs: strobe, mode, clear, err_clr.
  - Outputs: count, dir, err.
- The top module holds the prescaler, shadow registers, register decode and read mux, and a generate loop over NUM_CH.

Test Plan:
- Reset: assert reset mid-count -> all reads 0, except addr 0x8=0x80 and 0x9=0xAA; uo_out=0.
- Debounce: cmp=0, ch0 A toggled with 3-cycle glitches -> count unchanged; A high for 8 cycles -> debounced at the 8th strobe.
- Modes: cmp=0, ch1 driven through one full forward cycle -> shadow after capture = 4 (x4), 2 (x2), 1 (x1), 0 (off). The reverse cycle in x4 -> 0xFFFC and direction[1]=0.
- Wrap and width: preload ch2 to 0xFFFF via 65535 up counts (or CNT_WIDTH=8 build with 255 counts) -> the next up count reads 0x0000; a down count from 0 reads 0xFFFF.
- Capture-and-clear: write 0xB=0x01 on the same cycle ch0 counts up from 5 -> shadow0=5, a second capture gives 1; ch3 is unaffected.
- Illegal transition: ch3 A and B flip together -> count unchanged, status[7]=1. Writing 0x80 to 0xA clears it; a set on the same cycle as the clear leaves it 1.

Source files
------------

// File: rtl/quad_encoder_pkg.sv
// Shared constants and helpers for the quadrature encoder bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quad_encoder_pkg;

    typedef enum logic [1:0] {
        MODE_X1  = 2'b00,
        MODE_X2  = 2'b01,
        MODE_X4  = 2'b10,
        MODE_OFF = 2'b11
    } mode_e;

    localparam logic [3:0] ADDR_CNT_BASE = 4'h0;
    localparam logic [3:0] ADDR_DEB_CMP  = 4'h8;
    localparam logic [3:0] ADDR_MODE     = 4'h9;
    localparam logic [3:0] ADDR_STATUS   = 4'hA;
    localparam logic [3:0] ADDR_CAPTURE  = 4'hB;

    localparam logic [7:0] DEB_CMP_RST = 8'd128;
    localparam logic [7:0] MODE_RST    = 8'hAA;

    // Next state in the forward (count-up) Gray sequence {A,B}: 00->10->11->01->00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return {~ab[0], ab[1]};
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: A/B debouncers, transition decoder, wrapping counter, direction, sticky error.
// Latency: counter/dir/err update one clk after the debounced pins change.
// Backpressure: none; every strobe and every transition is consumed immediately.
module quad_channel
    import quad_encoder_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int HIST_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  logic                 a,
    input  logic                 b,
    input  logic [1:0]           mode,
    input  logic                 clear,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 dir,
    output logic                 err
);

    // Index 1 is A, index 0 is B, so the vectors read as {A,B}.
    logic [1:0]          pin;
    logic [1:0]          db;
    logic [1:0]          prev;
    logic [HIST_LEN-1:0] hist     [2];
    logic [HIST_LEN-1:0] hist_nxt [2];

    logic                 up;
    logic                 down;
    logic                 err_set;
    logic [CNT_WIDTH-1:0] delta;

    assign pin = {a, b};

    // Candidate history after this strobe; the debounced level is judged on it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hist_nxt[i] = {hist[i][HIST_LEN-2:0], pin[i]};
        end
    end

    // Shift pins in on strobe; output flips only on a unanimous history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                hist[i] <= '0;
            end
            db <= '0;
        end else if (strobe) begin
            for (int i = 0; i < 2; i++) begin
                hist[i] <= hist_nxt[i];
                if (&hist_nxt[i]) begin
                    db[i] <= 1'b1;
                end else if (~|hist_nxt[i]) begin
                    db[i] <= 1'b0;
                end
            end
        end
    end

    // Classify the prev->current debounced transition under the active mode.
    always_comb begin
        logic fwd;
        logic rev;
        logic a_chg;
        fwd     = (db == fwd_next(prev));
        rev     = (prev == fwd_next(db));
        a_chg   = prev[1] ^ db[1];
        up      = 1'b0;
        down    = 1'b0;
        err_set = (&(prev ^ db)) && (mode != MODE_OFF);
        case (mode_e'(mode))
            MODE_X4: begin
                up   = fwd;
                down = rev;
            end
            MODE_X2: begin
                up   = fwd && a_chg;
                down = rev && a_chg;
            end
            MODE_X1: begin
                up   = (prev == 2'b00) && (db == 2'b10);
                down = (prev == 2'b10) && (db == 2'b00);
            end
            default: begin
                up   = 1'b0;
                down = 1'b0;
            end
        endcase
        delta = '0;
        if (up) begin
            delta = CNT_WIDTH'(1);
        end else if (down) begin
            delta = '1;
        end
    end

    // Counter, direction, sticky error; a clear still keeps this cycle's count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 2'b00;
            count <= '0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            prev <= db;
            if (clear) begin
                count <= delta;
            end else begin
                count <= count + delta;
            end
            if (up || down) begin
                dir <= up;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder peripheral with shadowed counters behind an 8-bit register port.
// Latency: writes take effect on the next clk; reads are combinational from address.
// Backpressure: none; the register port accepts a write every cycle.
module quad_encoder_bank
    import quad_encoder_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int HIST_LEN     = 8,
    parameter int STROBE_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [STROBE_WIDTH-1:0] prescaler;
    logic                    strobe;
    logic [7:0]              debounce_cmp;
    logic [7:0]              mode;
    logic                    wr_status;
    logic                    wr_capture;

    logic [CNT_WIDTH-1:0] count  [4];
    logic [CNT_WIDTH-1:0] shadow [4];
    logic [3:0]           dir_bits;
    logic [3:0]           err_bits;
    logic [15:0]          sel_cnt;

    assign uo_out     = 8'h00;
    assign strobe     = (prescaler == STROBE_WIDTH'(debounce_cmp));
    assign wr_status  = data_write && (address == ADDR_STATUS);
    assign wr_capture = data_write && (address == ADDR_CAPTURE);

    // Debounce sample prescaler: restart on strobe, else free-run (wraps if cmp was lowered past it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (strobe) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + STROBE_WIDTH'(1);
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounce_cmp <= DEB_CMP_RST;
            mode         <= MODE_RST;
        end else if (data_write) begin
            if (address == ADDR_DEB_CMP) begin
                debounce_cmp <= data_in;
            end
            if (address == ADDR_MODE) begin
                mode <= data_in;
            end
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        if (n < NUM_CH) begin : g_on
            quad_channel #(
                .CNT_WIDTH (CNT_WIDTH),
                .HIST_LEN  (HIST_LEN)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .strobe  (strobe),
                .a       (ui_in[2*n]),
                .b       (ui_in[2*n+1]),
                .mode    (mode[2*n+:2]),
                .clear   (wr_capture && data_in[n]),
                .err_clr (wr_status && data_in[4+n]),
                .count   (count[n]),
                .dir     (dir_bits[n]),
                .err     (err_bits[n])
            );
        end else begin : g_off
            assign count[n]    = '0;
            assign dir_bits[n] = 1'b0;
            assign err_bits[n] = 1'b0;
        end
    end

    // Atomic snapshot of every live counter, pre-count value on a same-cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_capture) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= count[i];
            end
        end
    end

    // Combinational read mux; absent channels and unmapped addresses read zero.
    always_comb begin
        sel_cnt  = 16'(shadow[address[2:1]]);
        data_out = 8'h00;
        case (address)
            ADDR_DEB_CMP: data_out = debounce_cmp;
            ADDR_MODE:    data_out = mode;
            ADDR_STATUS:  data_out = {err_bits, dir_bits};
            default: begin
                if ((address & 4'h8) == ADDR_CNT_BASE) begin
                    data_out = address[0] ? sel_cnt[15:8] : sel_cnt[7:0];
                end
            end
        endcase
    end

endmodule
